// File: rtl/pwm_capture_if.sv
// Bus between a PWM capture block and its consumer: control inputs and measurement results.
interface pwm_capture_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             pwm_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output enable, pwm_in,
    input  period, high_time, valid, stuck, stuck_level
  );

  modport slave (
    input  enable, pwm_in,
    output period, high_time, valid, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles, once per PWM
// cycle, and flags a line with no rising edge for 2^WIDTH-1 cycles as stuck.
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  pwm_capture_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic [WIDTH-1:0]       per_cnt;
  logic [WIDTH-1:0]       hi_cnt;
  logic [WIDTH-1:0]       period_q;
  logic [WIDTH-1:0]       high_time_q;
  logic                   valid_q;
  logic                   stuck_q;
  logic                   stuck_level_q;

  logic                   s;
  logic                   rise;
  logic                   per_full;
  logic [WIDTH-1:0]       per_inc;
  logic [WIDTH-1:0]       hi_inc;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_d;
  assign per_full = (per_cnt == ALL_ONES);
  assign per_inc  = per_full ? per_cnt : per_cnt + ONE;
  assign hi_inc   = (s && (hi_cnt != ALL_ONES)) ? hi_cnt + ONE : hi_cnt;

  // NOTE: every register here, including the synchronizer, uses <= so all flops sample
  // the same pre-edge values; blocking assignments would make results order-dependent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sync_q        <= '0;
      s_d           <= 1'b0;
      per_cnt       <= '0;
      hi_cnt        <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      s_d     <= s;
      valid_q <= 1'b0;
      if (stuck_q) stuck_level_q <= s;

      if (!bus.enable) begin
        // Disable wins over a coincident rise: nothing is reported, capture restarts later.
        state   <= IDLE;
        per_cnt <= '0;
        hi_cnt  <= '0;
        stuck_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ARM;
            per_cnt <= '0;
            hi_cnt  <= '0;
          end
          ARM: begin
            if (rise) begin
              state   <= MEAS;
              per_cnt <= ONE;
              hi_cnt  <= ONE;
              stuck_q <= 1'b0;
            end else if (per_full) begin
              stuck_q       <= 1'b1;
              stuck_level_q <= s;
            end else begin
              per_cnt <= per_inc;
            end
          end
          MEAS: begin
            if (rise) begin
              period_q    <= per_cnt;
              high_time_q <= hi_cnt;
              valid_q     <= 1'b1;
              stuck_q     <= 1'b0;
              per_cnt     <= ONE;
              hi_cnt      <= ONE;
            end else if (per_full) begin
              // Timeout: keep per_cnt saturated so ARM keeps asserting stuck until a rise.
              state         <= ARM;
              stuck_q       <= 1'b1;
              stuck_level_q <= s;
            end else begin
              per_cnt <= per_inc;
              hi_cnt  <= hi_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period      = period_q;
  assign bus.high_time   = high_time_q;
  assign bus.valid       = valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = stuck_level_q;

endmodule
